sprite_state_writer: RTL and testbench

//  Producer side of the sprite-state words in system RAM. Once per frame, during the

---
 rtl/sprite_state_writer.sv | 153 +++++++++++++++
 tb/tb_sprite_state_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_state_writer.sv
// Sprite-state producer: once per frame, in the vsync-low window, moves and animates the
// sprite, then writes x, y and frame index to RAM. Define SPRITE_WRAP_EN to wrap x/y instead of clamping.
module sprite_state_writer #(
  parameter int                          SYS_DATA_WIDTH = 18,
  parameter int                          SYS_ADDR_WIDTH = 16,
  parameter logic [SYS_ADDR_WIDTH-1:0]   BASE_ADDR      = 'h1000,
  parameter int                          DISPLAY_W      = 640,
  parameter int                          DISPLAY_H      = 480,
  parameter int                          GLYPH_W        = 17,
  parameter int                          GLYPH_H        = 32,
  parameter int                          STEP           = 2,
  parameter int                          NUM_FRAMES     = 3,
  parameter int                          ANIM_DIV       = 4,
  parameter int                          X_INIT         = 0,
  parameter int                          Y_INIT         = 448
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      sys_gnt,
  output logic                      sys_req,
  output logic                      sys_we,
  output logic [SYS_ADDR_WIDTH-1:0] sys_addr,
  output logic [SYS_DATA_WIDTH-1:0] sys_wdata,
  output logic                      busy,
  output logic                      overrun,
  output logic [2:0]                dbg_state
);
  // Handshake: in a WR_* state sys_req is held high and the word is written on every
  // cycle where sys_we (= sys_gnt) is high; address/data stay put until then.

  localparam int DW   = SYS_DATA_WIDTH;
  localparam int SW   = SYS_DATA_WIDTH + 1;
  localparam int XMAX = DISPLAY_W - GLYPH_W;
  localparam int YMAX = DISPLAY_H - GLYPH_H;
  localparam int MW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int CW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [MW-1:0] M_LAST    = MW'(NUM_FRAMES - 1);
  localparam logic [CW-1:0] ANIM_LAST = CW'(ANIM_DIV - 1);

  typedef enum logic [2:0] {IDLE, CALC, WR_X, WR_Y, WR_M} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   x, y, x_nx, y_nx;
  logic [MW-1:0]   m, m_nx;
  logic [CW-1:0]   anim_cnt, anim_nx;
  logic            vsync_d, fall, rise, abort, any_btn;

  // Signed arithmetic one bit wider than the word, so a step below zero is visible.
  function automatic logic [DW-1:0] move(input logic [DW-1:0] p, input logic dec,
                                         input logic inc, input int maxv);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] lim;
    s   = signed'({1'b0, p});
    lim = SW'(maxv);
    if (dec && !inc)      s = s - SW'(STEP);
    else if (inc && !dec) s = s + SW'(STEP);
`ifdef SPRITE_WRAP_EN
    if (s[SW-1])       s = lim;
    else if (s > lim)  s = '0;
`else
    if (s[SW-1])       s = '0;
    else if (s > lim)  s = lim;
`endif
    return s[DW-1:0];
  endfunction

  assign fall    = vsync_d & ~vsync;
  assign rise    = ~vsync_d & vsync;
  assign any_btn = btn_left | btn_right | btn_up | btn_down;

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    m_nx     = m;
    anim_nx  = anim_cnt;
    abort    = 1'b0;
    case (state)
      IDLE: if (fall) state_nx = CALC;
      CALC: begin
        x_nx = move(x, btn_left, btn_right, XMAX);
        y_nx = move(y, btn_up, btn_down, YMAX);
        if (!any_btn) begin
          m_nx    = '0;
          anim_nx = '0;
        end else if (anim_cnt == ANIM_LAST) begin
          anim_nx = '0;
          m_nx    = (m == M_LAST) ? '0 : m + 1'b1;
        end else begin
          anim_nx = anim_cnt + 1'b1;
        end
        state_nx = WR_X;
      end
      WR_X:    if (sys_gnt) state_nx = WR_Y;
      WR_Y:    if (sys_gnt) state_nx = WR_M;
      WR_M:    if (sys_gnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A rising vsync ends the safe window; the burst is dropped, the new state is kept.
    if (rise && state != IDLE) begin
      state_nx = IDLE;
      abort    = 1'b1;
    end
  end

  assign sys_req   = (state == WR_X) || (state == WR_Y) || (state == WR_M);
  assign sys_we    = sys_req & sys_gnt;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= DW'(X_INIT);
      y         <= DW'(Y_INIT);
      m         <= '0;
      anim_cnt  <= '0;
      vsync_d   <= 1'b1;
      overrun   <= 1'b0;
      sys_addr  <= '0;
      sys_wdata <= '0;
    end else begin
      state    <= state_nx;
      x        <= x_nx;
      y        <= y_nx;
      m        <= m_nx;
      anim_cnt <= anim_nx;
      vsync_d  <= vsync;
      overrun  <= abort;
      case (state_nx)
        WR_X: begin
          sys_addr  <= BASE_ADDR;
          sys_wdata <= x_nx;
        end
        WR_Y: begin
          sys_addr  <= BASE_ADDR + SYS_ADDR_WIDTH'(1);
          sys_wdata <= y_nx;
        end
        WR_M: begin
          sys_addr  <= BASE_ADDR + SYS_ADDR_WIDTH'(2);
          sys_wdata <= {{(DW-MW){1'b0}}, m_nx};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_state_writer.sv
// Bench for sprite_state_writer: a table of per-frame button/grant patterns with expected
// written words, plus hand sequences for reset mid-burst.
module tb_sprite_state_writer;
  localparam int          DW   = 18;
  localparam int          AW   = 16;
  localparam logic [15:0] BASE = 16'h1000;
`ifdef SPRITE_WRAP_EN
  localparam int WRAP = 1;
`else
  localparam int WRAP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, vsync, btn_left, btn_right, btn_up, btn_down, sys_gnt;
  logic          sys_req, sys_we, busy, overrun;
  logic [AW-1:0] sys_addr;
  logic [DW-1:0] sys_wdata;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  sprite_state_writer dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .sys_gnt(sys_gnt), .sys_req(sys_req), .sys_we(sys_we), .sys_addr(sys_addr),
    .sys_wdata(sys_wdata), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // mode: 0 = grant always, 1 = grant withheld 5 cycles in WR_Y, 2 = no grant (abort)
  typedef struct {
    logic       rst;
    logic [3:0] btn;  // {left, right, up, down}
    int         mode;
    int         ex, ey, em;
  } vec_t;

  vec_t             vecs[26];
  logic [AW+DW-1:0] exp_q[$];
  int n_vec = 0, n_miss = 0;
  int gnt_mode, stall_left, cyc, first_we, last_we, req_cycles, ovr_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [AW+DW-1:0] e;
    @(posedge clk);
    #1;
    case (gnt_mode)
      1: if (sys_req && sys_addr == BASE + 16'd1 && stall_left > 0) begin
           sys_gnt = 1'b0;
           stall_left--;
         end else sys_gnt = 1'b1;
      2:       sys_gnt = 1'b0;
      default: sys_gnt = 1'b1;
    endcase
    #1;
    cyc++;
    if (sys_req) req_cycles++;
    if (overrun) ovr_cnt++;
    if (gnt_mode == 1 && sys_req && !sys_gnt) begin
      check("stall_we", sys_we, 0);
      check("stall_addr", sys_addr, BASE + 16'd1);
    end
    if (sys_we) begin
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got %0h/%0h expected none", sys_addr, sys_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write", {sys_addr, sys_wdata}, e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vsync = 1'b1;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    gnt_mode = 0;
    exp_q.delete();
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  task automatic run_frame(input vec_t v);
    {btn_left, btn_right, btn_up, btn_down} = v.btn;
    gnt_mode   = v.mode;
    stall_left = 5;
    cyc        = 0;
    first_we   = -1;
    last_we    = -1;
    req_cycles = 0;
    ovr_cnt    = 0;
    if (v.mode != 2) begin
      exp_q.push_back({BASE,          DW'(v.ex)});
      exp_q.push_back({BASE + 16'd1,  DW'(v.ey)});
      exp_q.push_back({BASE + 16'd2,  DW'(v.em)});
    end
    vsync = 1'b0;
    repeat (12) step();
    vsync = 1'b1;
    repeat (4) step();
    check("drained", exp_q.size(), 0);
    exp_q.delete();
    if (v.mode == 0) begin
      check("first_write_latency", first_we, 2);
      check("burst_span", last_we - first_we, 2);
    end
    if (v.mode == 1) check("stalled_burst_len", req_cycles, 8);
    check("overrun_pulses", ovr_cnt, (v.mode == 2) ? 1 : 0);
    check("busy_end", busy, 0);
    check("state_end", dbg_state, 0);
  endtask

  initial begin
    vec_t hv;
    vecs[0] = '{1'b0, 4'b0000, 0, 0, 448, 0};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{1'b0, 4'b0100, 0, 2 * i, 448, (i < 4) ? 0 : (i < 8) ? 1 : 2};
    vecs[9]  = '{1'b0, 4'b0000, 0, 16, 448, 0};
    vecs[10] = '{1'b0, 4'b0010, 0, 16, 446, 0};
    vecs[11] = '{1'b0, 4'b0010, 0, 16, 444, 0};
    vecs[12] = '{1'b0, 4'b0011, 0, 16, 444, 0};
    vecs[13] = '{1'b0, 4'b1000, 0, 14, 444, 1};
    vecs[14] = '{1'b0, 4'b0000, 0, 14, 444, 0};
    vecs[15] = '{1'b0, 4'b0001, 0, 14, 446, 0};
    vecs[16] = '{1'b0, 4'b0001, 0, 14, 448, 0};
    vecs[17] = '{1'b0, 4'b0001, 0, 14, WRAP ? 0 : 448, 0};
    vecs[18] = '{1'b1, 4'b1000, 0, WRAP ? 623 : 0, 448, 0};
    vecs[19] = '{1'b1, 4'b1101, 0, 0, WRAP ? 0 : 448, 0};
    vecs[20] = '{1'b0, 4'b1101, 0, 0, WRAP ? 2 : 448, 0};
    vecs[21] = '{1'b0, 4'b1101, 0, 0, WRAP ? 4 : 448, 0};
    vecs[22] = '{1'b0, 4'b1101, 0, 0, WRAP ? 6 : 448, 1};
    vecs[23] = '{1'b0, 4'b0000, 1, 0, WRAP ? 6 : 448, 0};
    vecs[24] = '{1'b1, 4'b0100, 2, 0, 0, 0};
    vecs[25] = '{1'b0, 4'b0100, 0, 4, 448, 0};

    reset   = 1'b1;
    vsync   = 1'b1;
    sys_gnt = 1'b1;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    do_reset();
    check("reset_req", sys_req, 0);
    check("reset_we", sys_we, 0);
    check("reset_addr", sys_addr, 0);
    check("reset_wdata", sys_wdata, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);

    for (int i = 0; i < 26; i++) begin
      if (vecs[i].rst) do_reset();
      run_frame(vecs[i]);
    end

    // Reset asserted while a write is pending must clear everything at once.
    gnt_mode = 2;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0100;
    vsync = 1'b0;
    repeat (3) step();
    check("busy_mid_burst", busy, 1);
    check("req_mid_burst", sys_req, 1);
    reset    = 1'b1;
    vsync    = 1'b1;
    gnt_mode = 0;
    step();
    check("we_after_reset", sys_we, 0);
    check("busy_after_reset", busy, 0);
    check("addr_after_reset", sys_addr, 0);
    reset = 1'b0;
    repeat (2) step();
    hv = '{1'b0, 4'b0000, 0, 0, 448, 0};
    run_frame(hv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
